// File: rtl/seq_add_sub_pkg.sv
// Shared definitions for the sequential adder/subtractor: FSM states, op codes
// and the default CPU data width.
package seq_add_sub_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/rc_add_slice.sv
// Combinational W-bit ripple-carry adder built from a chain of full-adder cells.
// Also exposes the carry into the MSB stage so the caller can derive signed overflow.
module rc_add_slice #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         c_msb
);

  logic [W:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co    = c[W];
  assign c_msb = c[W-1];

endmodule

// File: rtl/seq_add_sub.sv
// Multi-cycle adder/subtractor: one SLICE-bit ripple slice per clock with the
// inter-slice carry registered, START/BUSY/DONE handshake and CO/OVF/ZERO flags.
module seq_add_sub
  import seq_add_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W,
  parameter int unsigned SLICE = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             SnA,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Y,
  output logic             CO,
  output logic             OVF,
  output logic             ZERO,
  output logic             BUSY,
  output logic             DONE
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if ((SLICE == 0) || (WIDTH % SLICE != 0)) begin : g_bad_slice
    $error("seq_add_sub: WIDTH must be a non-zero multiple of SLICE");
  end

  state_e             state;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   acc;
  logic               carry;
  logic [IDX_W-1:0]   idx;

  int unsigned        lsb;
  logic [SLICE-1:0]   a_sl;
  logic [SLICE-1:0]   b_sl;
  logic [SLICE-1:0]   s_sl;
  logic               co_sl;
  logic               c_msb_sl;
  logic [WIDTH-1:0]   res_c;
  logic               last_c;

  assign lsb    = 32'(idx) * SLICE;
  assign a_sl   = a_q[lsb +: SLICE];
  assign b_sl   = b_q[lsb +: SLICE];
  assign last_c = (idx == IDX_W'(NSLICE - 1));

  rc_add_slice #(.W(SLICE)) u_slice (
    .a     (a_sl),
    .b     (b_sl),
    .ci    (carry),
    .s     (s_sl),
    .co    (co_sl),
    .c_msb (c_msb_sl)
  );

  // Accumulator with the current slice merged in; becomes Y on the last slice.
  always_comb begin
    res_c = acc;
    res_c[lsb +: SLICE] = s_sl;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= ST_IDLE;
      a_q   <= '0;
      b_q   <= '0;
      acc   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      Y     <= '0;
      CO    <= 1'b0;
      OVF   <= 1'b0;
      ZERO  <= 1'b0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      DONE <= 1'b0;
      unique case (state)
        ST_IDLE, ST_FIN: begin
          BUSY <= 1'b0;
          if (START) begin
            a_q   <= A;
            b_q   <= (SnA == OP_SUB) ? ~B : B;
            carry <= SnA;
            acc   <= '0;
            idx   <= '0;
            BUSY  <= 1'b1;
            state <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          acc   <= res_c;
          carry <= co_sl;
          idx   <= idx + IDX_W'(1);
          if (last_c) begin
            // Signed overflow: carry into the MSB differs from carry out of it.
            Y     <= res_c;
            CO    <= co_sl;
            OVF   <= co_sl ^ c_msb_sl;
            ZERO  <= (res_c == '0);
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            state <= ST_FIN;
          end
        end
        default: begin
          BUSY  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_add_sub.sv
// Scoreboard bench for seq_add_sub: directed vectors on a 32/8 instance and an
// 8/1 instance, expected results queued at issue and checked when DONE pulses.
module tb_seq_add_sub;

  typedef struct {
    logic [31:0] y;
    logic        co;
    logic        ovf;
    logic        zero;
    int unsigned cyc;
  } exp_t;

  logic        CLK;
  logic        RST;
  logic        START, SnA;
  logic [31:0] A, B, Y;
  logic        CO, OVF, ZERO, BUSY, DONE;
  logic        START8, SnA8;
  logic [7:0]  A8, B8, Y8;
  logic        CO8, OVF8, ZERO8, BUSY8, DONE8;

  int unsigned cyc;
  int          total;
  int          bad;
  logic [31:0] last_y;
  exp_t        q[$];
  exp_t        q8[$];

  seq_add_sub #(.WIDTH(32), .SLICE(8)) u_dut (
    .CLK(CLK), .RST(RST), .START(START), .SnA(SnA), .A(A), .B(B),
    .Y(Y), .CO(CO), .OVF(OVF), .ZERO(ZERO), .BUSY(BUSY), .DONE(DONE)
  );

  seq_add_sub #(.WIDTH(8), .SLICE(1)) u_dut8 (
    .CLK(CLK), .RST(RST), .START(START8), .SnA(SnA8), .A(A8), .B(B8),
    .Y(Y8), .CO(CO8), .OVF(OVF8), .ZERO(ZERO8), .BUSY(BUSY8), .DONE(DONE8)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic op,
                       input logic [31:0] y, input logic co, input logic ovf, input logic zero);
    exp_t e;
    A = a; B = b; SnA = op; START = 1'b1;
    e = '{y: y, co: co, ovf: ovf, zero: zero, cyc: cyc + 1 + 4};
    q.push_back(e);
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic op,
                        input logic [7:0] y, input logic co, input logic ovf, input logic zero);
    exp_t e;
    A8 = a; B8 = b; SnA8 = op; START8 = 1'b1;
    e = '{y: 32'(y), co: co, ovf: ovf, zero: zero, cyc: cyc + 1 + 8};
    q8.push_back(e);
    @(negedge CLK);
    START8 = 1'b0;
  endtask

  // Monitor for the 32-bit instance
  always @(negedge CLK) begin
    if (RST && DONE) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("y", Y, e.y);
        chk("co", 32'(CO), 32'(e.co));
        chk("ovf", 32'(OVF), 32'(e.ovf));
        chk("zero", 32'(ZERO), 32'(e.zero));
        chk("done_cycle", cyc, e.cyc);
        chk("busy_at_done", 32'(BUSY), 32'd0);
        last_y = e.y;
      end
    end
  end

  // Monitor for the 8-bit, 1-bit-slice instance
  always @(negedge CLK) begin
    if (RST && DONE8) begin
      if (q8.size() == 0) begin
        chk("unexpected_done8", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q8.pop_front();
        chk("y8", 32'(Y8), e.y);
        chk("co8", 32'(CO8), 32'(e.co));
        chk("ovf8", 32'(OVF8), 32'(e.ovf));
        chk("zero8", 32'(ZERO8), 32'(e.zero));
        chk("done_cycle8", cyc, e.cyc);
      end
    end
  end

  initial begin
    total = 0; bad = 0; last_y = '0;
    RST = 1'b0; START = 1'b0; SnA = 1'b0; A = '0; B = '0;
    START8 = 1'b0; SnA8 = 1'b0; A8 = '0; B8 = '0;
    tick(2);
    chk("rst_y", Y, 32'd0);
    chk("rst_flags", {28'd0, CO, OVF, ZERO, BUSY}, 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_y8", 32'(Y8), 32'd0);
    RST = 1'b1;
    tick(1);

    // Basic add/sub vectors
    issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    tick(5);
    issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    tick(5);
    issue(32'd5, 32'd7, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    tick(5);

    // Subtract with overflow; START pulse during RUN must be ignored
    issue(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    tick(1);
    A = 32'h1234_0000; B = 32'h0000_4321; SnA = 1'b0; START = 1'b1;
    chk("hold_y_in_run", Y, last_y);
    chk("busy_in_run", 32'(BUSY), 32'd1);
    tick(1);
    START = 1'b0;
    tick(4);

    // Back-to-back with START held: second op captured on the FIN edge
    A = 32'd3; B = 32'd4; SnA = 1'b0; START = 1'b1;
    q.push_back('{y: 32'd7, co: 1'b0, ovf: 1'b0, zero: 1'b0, cyc: cyc + 1 + 4});
    tick(1);
    A = 32'd10; B = 32'd3; SnA = 1'b1;
    q.push_back('{y: 32'd7, co: 1'b1, ovf: 1'b0, zero: 1'b0, cyc: cyc + 5 + 4});
    tick(5);
    START = 1'b0;
    tick(6);

    // Asynchronous reset during RUN abandons the operation
    issue(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0);
    tick(1);
    RST = 1'b0;
    #1;
    chk("midrst_y", Y, 32'd0);
    chk("midrst_flags", {28'd0, CO, OVF, ZERO, BUSY}, 32'd0);
    chk("midrst_done", 32'(DONE), 32'd0);
    void'(q.pop_back());
    last_y = '0;
    @(negedge CLK);
    RST = 1'b1;
    tick(6);
    issue(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0);
    tick(5);
    issue(32'h55, 32'h55, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1);
    tick(5);

    // Narrow instance, one bit per cycle
    issue8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    tick(10);
    issue8(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
    tick(10);

    chk("pending_results", 32'(q.size()), 32'd0);
    chk("pending_results8", 32'(q8.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
